// File: rtl/rearrng_wr_ctrl_pkg.sv
// rtl/rearrng_wr_ctrl_pkg.sv - shared FSM encoding and bank constants for the rearrange write controller
package rearrng_wr_ctrl_pkg;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } wr_state_e;

    localparam logic PING = 1'b0;
    localparam logic PONG = 1'b1;

    function automatic logic [1:0] bank_sel(input logic bank);
        return (bank == PONG) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rearrng_addr_gen.sv
// rtl/rearrng_addr_gen.sv - row/col beat counters with transposed (column-major) write address
module rearrng_addr_gen
    import rearrng_wr_ctrl_pkg::*;
#(
    parameter int NUM_ROWS = 8,
    parameter int ROW_LEN  = 8,
    parameter int ADDRW    = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             adv,
    output logic [ADDRW-1:0] addr,
    output logic             last
);

    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          row_end;
    logic          col_end;

    assign row_end = (row == RW'(NUM_ROWS - 1));
    assign col_end = (col == CW'(ROW_LEN - 1));
    assign last    = row_end & col_end;

    // Transpose so the reader can scan the bank linearly column by column.
    assign addr = ADDRW'(col) * ADDRW'(NUM_ROWS) + ADDRW'(row);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rearrng_wr_ctrl.sv
// rtl/rearrng_wr_ctrl.sv - ping-pong bank write controller transposing a row-major sample stream
module rearrng_wr_ctrl
    import rearrng_wr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ROWS   = 8,
    parameter int ROW_LEN    = 8,
    parameter int ADDRW      = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [1:0]            ram_ena,
    output logic                  ram_wea,
    output logic [ADDRW-1:0]      ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dia,
    output logic [1:0]            bank_full,
    input  logic [1:0]            rd_release,
    output logic                  err_tlast
);

    wr_state_e        state;
    wr_state_e        state_next;
    logic             wr_bank;
    logic             wr_bank_next;
    logic             pend;
    logic             beat;
    logic             last;
    logic             final_beat;
    logic             beat_bank;
    logic             tgt_bank_next;
    logic [1:0]       set_mask;
    logic [1:0]       clr_mask;
    logic [1:0]       full_next;
    logic [ADDRW-1:0] addr;

    rearrng_addr_gen #(
        .NUM_ROWS (NUM_ROWS),
        .ROW_LEN  (ROW_LEN),
        .ADDRW    (ADDRW)
    ) u_addr_gen (
        .clk    (clk),
        .resetn (resetn),
        .adv    (beat),
        .addr   (addr),
        .last   (last)
    );

    assign beat       = s_axis_tvalid & s_axis_tready;
    assign final_beat = beat & last;
    // A beat taken while the finished bank is still being flagged belongs to the other bank.
    assign beat_bank  = pend ? ~wr_bank : wr_bank;

    always_comb begin
        set_mask      = pend ? bank_sel(wr_bank) : 2'b00;
        clr_mask      = rd_release & ~set_mask;
        full_next     = (bank_full & ~clr_mask) | set_mask;
        wr_bank_next  = pend ? ~wr_bank : wr_bank;
        tgt_bank_next = final_beat ? ~wr_bank_next : wr_bank_next;
        state_next    = state;
        case (state)
            FILL:    if (full_next[tgt_bank_next])  state_next = WAIT;
            WAIT:    if (!full_next[tgt_bank_next]) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= FILL;
            s_axis_tready <= 1'b0;
            wr_bank       <= PING;
            bank_full     <= 2'b00;
            pend          <= 1'b0;
            err_tlast     <= 1'b0;
        end else begin
            state         <= state_next;
            s_axis_tready <= (state_next == FILL);
            wr_bank       <= wr_bank_next;
            bank_full     <= full_next;
            pend          <= final_beat;
            if (beat && (s_axis_tlast != last)) begin
                err_tlast <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_ena   <= 2'b00;
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dia   <= '0;
        end else if (beat) begin
            ram_ena   <= bank_sel(beat_bank);
            ram_wea   <= 1'b1;
            ram_addra <= addr;
            ram_dia   <= s_axis_tdata;
        end else begin
            ram_ena   <= 2'b00;
            ram_wea   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rearrng_wr_ctrl.sv
// tb/tb_rearrng_wr_ctrl.sv - directed self-checking bench for rearrng_wr_ctrl
module tb_rearrng_wr_ctrl;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int RL = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [1:0]    ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dia;
    logic [1:0]    bank_full;
    logic [1:0]    rd_release = 2'b00;
    logic          err_tlast;

    int total = 0;
    int bad   = 0;

    logic [1:0]    q_ena[$];
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];

    always #5 clk = ~clk;

    rearrng_wr_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_ROWS   (NR),
        .ROW_LEN    (RL),
        .ADDRW      (AW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .ram_ena       (ram_ena),
        .ram_wea       (ram_wea),
        .ram_addra     (ram_addra),
        .ram_dia       (ram_dia),
        .bank_full     (bank_full),
        .rd_release    (rd_release),
        .err_tlast     (err_tlast)
    );

    always @(negedge clk) begin
        if (ram_wea) begin
            q_ena.push_back(ram_ena);
            q_addr.push_back(ram_addra);
            q_data.push_back(ram_dia);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_ena.delete();
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic send(input int d, input bit l);
        bit rdy;
        int n;
        rdy = 1'b0;
        n = 0;
        s_axis_tdata  = DW'(d);
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!rdy && n < 300) begin
            rdy = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!rdy) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        rd_release    = 2'b00;
        @(negedge clk);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_ena", ram_ena, 0);
        chk("rst_wea", ram_wea, 0);
        chk("rst_addr", ram_addra, 0);
        chk("rst_data", ram_dia, 0);
        chk("rst_full", bank_full, 0);
        chk("rst_err", err_tlast, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_q();
        @(negedge clk);
        chk("tready_pre", s_axis_tready, 0);
        @(negedge clk);
        chk("tready_up", s_axis_tready, 1);
    endtask

    task automatic verify_frame(input logic [1:0] ena, input int base);
        chk("nwr", q_addr.size(), 64);
        for (int i = 0; i < q_addr.size() && i < 64; i++) begin
            chk("wr_ena", q_ena[i], ena);
            chk("wr_addr", q_addr[i], (i % 8) * 8 + i / 8);
            chk("wr_data", q_data[i], base + i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        do_reset();

        // gapless frame into ping
        for (int k = 0; k < 64; k++) send(k, k == 63);
        @(negedge clk);
        chk("t1_last_wea", ram_wea, 1);
        chk("t1_last_addr", ram_addra, 63);
        chk("t1_full_pre", bank_full, 2'b00);
        @(negedge clk);
        chk("t1_full", bank_full, 2'b01);
        chk("t1_err", err_tlast, 0);
        chk("t1_tready", s_axis_tready, 1);
        #1;
        verify_frame(2'b01, 0);

        // release of an empty bank is ignored
        @(posedge clk);
        #1;
        rd_release = 2'b10;
        @(posedge clk);
        #1;
        rd_release = 2'b00;
        @(negedge clk);
        chk("ign_rel", bank_full, 2'b01);

        // second frame fills pong, then both banks full
        clear_q();
        for (int k = 64; k < 128; k++) send(k, k == 127);
        @(negedge clk);
        chk("t2_tready_drop", s_axis_tready, 0);
        @(negedge clk);
        chk("t2_full", bank_full, 2'b11);
        #1;
        verify_frame(2'b10, 64);
        clear_q();
        s_axis_tdata  = 128;
        s_axis_tvalid = 1'b1;
        repeat (5) @(negedge clk);
        chk("t2_hold_tready", s_axis_tready, 0);
        #1;
        chk("t2_hold_nwr", q_addr.size(), 0);
        s_axis_tvalid = 1'b0;
        rd_release = 2'b01;
        @(posedge clk);
        #1;
        rd_release = 2'b00;
        chk("t2_rel_full", bank_full, 2'b10);
        chk("t2_rel_tready", s_axis_tready, 1);
        send(128, 1'b0);
        @(negedge clk);
        #1;
        chk("t2_b128_nwr", q_addr.size(), 1);
        if (q_addr.size() > 0) begin
            chk("t2_b128_ena", q_ena[0], 2'b01);
            chk("t2_b128_addr", q_addr[0], 0);
            chk("t2_b128_data", q_data[0], 128);
        end

        // random valid gaps
        do_reset();
        for (int k = 0; k < 64; k++) begin
            if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
            send(k, k == 63);
        end
        @(negedge clk);
        @(negedge clk);
        chk("t3_full", bank_full, 2'b01);
        #1;
        verify_frame(2'b01, 0);

        // early tlast
        do_reset();
        for (int k = 0; k < 64; k++) begin
            send(k, k == 10);
            if (k == 9)  chk("t4_err_before", err_tlast, 0);
            if (k == 10) chk("t4_err_set", err_tlast, 1);
        end
        @(negedge clk);
        @(negedge clk);
        chk("t4_err_sticky", err_tlast, 1);
        chk("t4_full", bank_full, 2'b01);
        #1;
        verify_frame(2'b01, 0);

        // reset in mid-frame
        do_reset();
        for (int k = 0; k < 30; k++) send(k, 1'b0);
        do_reset();
        for (int k = 0; k < 64; k++) send(k, k == 63);
        @(negedge clk);
        @(negedge clk);
        chk("t5_full", bank_full, 2'b01);
        chk("t5_err", err_tlast, 0);
        #1;
        verify_frame(2'b01, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rearrng_wr_ctrl.md
REARRNG_WR_CTRL -- requirements
Module: rearrng_wr_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, sample width; NUM_ROWS, default 8, chirps per frame; ROW_LEN, default 8, samples per chirp; ADDRW, default 6, bank address width, where ADDRW = clog2(NUM_ROWS*ROW_LEN).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input sample, row-major (chirp by chirp).
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sample accept.
- s_axis_tlast  in  1  final sample of frame.
- ram_ena  out  2  per-bank write enable (bit0 = ping, bit1 = pong).
- ram_wea  out  1  write strobe.
- ram_addra  out  ADDRW  write address.
- ram_dia  out  DATA_WIDTH  write data.
- bank_full  out  2  bank holds a complete frame.
- rd_release  in  2  one-cycle pulse from the reader: bank consumed.
- err_tlast  out  1  sticky framing error.

Function
REQ-004 A beat SHALL be accepted on a rising edge with s_axis_tvalid=1 and s_axis_tready=1.
REQ-005 s_axis_tready SHALL be 1 exactly when the current write bank has bank_full=0; it SHALL be registered.
REQ-006 Counters row (0..NUM_ROWS-1) and col (0..ROW_LEN-1) SHALL track accepted beats: col increments per beat; at col=ROW_LEN-1, col wraps to 0 and row increments.
REQ-007 Write address SHALL be col*NUM_ROWS + row, a transpose, so the downstream reader scans linearly in column-major order.
REQ-008 Write latency SHALL be 1 cycle: for a beat accepted at edge N, ram_ena[wr_bank]=1, ram_wea=1, ram_addra and ram_dia SHALL be valid in the cycle after N, and the RAM SHALL capture at edge N+1.
REQ-009 With no accepted beat, ram_ena=0 and ram_wea=0; ram_addra and ram_dia SHALL hold their last values.
REQ-010 On the final beat of a frame (row=NUM_ROWS-1, col=ROW_LEN-1):
- counters SHALL wrap to 0;
- bank_full[wr_bank] SHALL set at edge N+1, after the RAM write;
- wr_bank SHALL toggle at edge N+1.
REQ-011 FSM states:
- FILL: wr_bank has bank_full=0, tready=1.
- WAIT: wr_bank has bank_full=1, tready=0.
- FILL->WAIT on frame completion when the other bank is full.
- WAIT->FILL in the cycle after rd_release of wr_bank.
REQ-012 rd_release[b] SHALL clear bank_full[b] at the next edge. A release of a bank with bank_full=0 SHALL be ignored.
REQ-013 If rd_release[b] and completion of bank b coincide, completion SHALL win. This case cannot legally occur; it is defined for robustness only.
REQ-014 If both rd_release bits pulse together, both SHALL clear.
REQ-015 err_tlast SHALL set when tlast=1 on an accepted non-final beat, or tlast=0 on an accepted final beat. Counting SHALL be unaffected by tlast.
REQ-016 err_tlast SHALL clear only on reset.

Reset
REQ-017 During resetn=0, outputs SHALL be: s_axis_tready=0, ram_ena=0, ram_wea=0, ram_addra=0, ram_dia=0, bank_full=0, err_tlast=0. Internal state SHALL be: wr_bank=0, row=0, col=0, state FILL.
REQ-018 s_axis_tready SHALL rise on the first edge after resetn deasserts.
REQ-019 Reset mid-frame SHALL discard the partial frame with no bank_full assertion.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding (FILL, WAIT) and the bank index constants PING=0 and PONG=1.
REQ-021 The address generator (row/col counters plus transpose multiply-add) SHALL be a sub-module named rearrng_addr_gen. The top level SHALL contain the FSM, handshake and bank flags.

Verification (NUM_ROWS=8, ROW_LEN=8)
REQ-022 Stream 64 beats, data=0..63, tlast on beat 63, continuous valid -> beat k writes address (k%8)*8+k/8 in bank 0; bank_full=01 one cycle after the last strobe; err_tlast=0.
REQ-023 Stream 128 beats with no release -> bank_full=11; tready=0 after beat 127; beat 128 is held off with no strobe until rd_release=01, then tready=1 one cycle later and the write goes to bank 0 at address 0.
REQ-024 Random tvalid gaps (50%) over 64 beats -> addresses and data identical to the gapless run; no strobe in gap cycles.
REQ-025 tlast on beat 10 -> err_tlast=1 from the following cycle and stays 1; frame still completes at beat 63.
REQ-026 Assert resetn=0 at beat 30 -> all outputs zero; after release, 64 beats fill bank 0 starting at address 0 and bank_full=01.
REQ-027 rd_release=10 while bank_full=01 -> ignored, bank_full stays 01.
